// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_pkg
// Description : Shared AXI-Stream widths and the TX packet-buffer read-FSM
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_pkg;

    localparam int c_AXIS_DATA_W   = 64;
    localparam int c_AXIS_KEEP_W   = 8;
    // One stored beat is {tlast, tkeep, tdata}
    localparam int c_PKTBUF_WORD_W = 1 + c_AXIS_KEEP_W + c_AXIS_DATA_W;

    localparam int c_RD_STATE_W = 2;
    localparam logic [c_RD_STATE_W-1:0] c_RD_IDLE   = 2'd0;
    localparam logic [c_RD_STATE_W-1:0] c_RD_FETCH  = 2'd1;
    localparam logic [c_RD_STATE_W-1:0] c_RD_STREAM = 2'd2;

endpackage
`default_nettype wire

// File: rtl/eth_pktbuf_ram.sv
`default_nettype none
// ============================================================================
// Module      : eth_pktbuf_ram
// Description : Simple dual-port RAM, one write and one registered read port,
//               both on clk156. The read register holds its value while
//               i_rd_en is low.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_pktbuf_ram
    import eth_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = c_PKTBUF_WORD_W
) (
    input  logic              clk156,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] r_rd_data;

    // Write port
    always_ff @(posedge clk156) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port, one cycle latency
    always_ff @(posedge clk156) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/eth_tx_pktbuf.sv
`default_nettype none
// ============================================================================
// Module      : eth_tx_pktbuf
// Description : Store-and-forward TX packet buffer between eth_encap and the
//               MAC. Frames become visible to the reader only once their last
//               beat is committed; errored or oversize frames are rewound.
//               Optional macro PKTBUF_STATS_EN enables the frame counters.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_tx_pktbuf
    import eth_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic                     clk156,
    input  logic                     eth_rst_n,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tlast,
    input  logic                     s_axis_tuser,
    input  logic [c_AXIS_DATA_W-1:0] s_axis_tdata,
    input  logic [c_AXIS_KEEP_W-1:0] s_axis_tkeep,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tuser,
    output logic [c_AXIS_DATA_W-1:0] m_axis_tdata,
    output logic [c_AXIS_KEEP_W-1:0] m_axis_tkeep,
    output logic [7:0]               debug,
    output logic [31:0]              stat_tx_frames,
    output logic [31:0]              stat_drop_frames
);

    localparam logic [ADDR_W-1:0] c_PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0]          r_wr_ptr;
    logic [ADDR_W-1:0]          r_wr_commit;
    logic [ADDR_W-1:0]          r_rd_ptr;
    logic                       r_dropping;
    logic                       r_tready;
    logic                       r_pf_valid;
    logic [c_RD_STATE_W-1:0]    r_rd_state;
    logic                       r_m_valid;
    logic                       r_m_last;
    logic [c_AXIS_DATA_W-1:0]   r_m_data;
    logic [c_AXIS_KEEP_W-1:0]   r_m_keep;
    logic [c_PKTBUF_WORD_W-1:0] w_ram_rd_data;

    logic [ADDR_W-1:0] w_wr_ptr_inc;
    logic              w_full;
    logic              w_empty;
    logic              w_wr_beat;
    logic              w_discard;
    logic              w_ram_wr_en;
    logic              w_out_load;
    logic              w_rd_en;

    assign w_wr_ptr_inc = r_wr_ptr + c_PTR_ONE;
    assign w_full       = (w_wr_ptr_inc == r_rd_ptr);
    assign w_empty      = (r_rd_ptr == r_wr_commit);
    assign w_wr_beat    = s_axis_tvalid && r_tready;
    // Once a frame overflows, every remaining beat of it is thrown away
    assign w_discard    = r_dropping || w_full;
    assign w_ram_wr_en  = w_wr_beat && !w_discard;

    // Output register refills from the prefetch slot whenever it is free or
    // being consumed; a new RAM read is issued whenever the slot will be free.
    assign w_out_load = r_pf_valid && (!r_m_valid || m_axis_tready);
    assign w_rd_en    = !w_empty && (!r_pf_valid || w_out_load);

    eth_pktbuf_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (c_PKTBUF_WORD_W)
    ) u_ram (
        .clk156    (clk156),
        .i_wr_en   (w_ram_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_ram_rd_data)
    );

    // Write side: pointer advance, commit on good tlast, rewind on bad frame
    always_ff @(posedge clk156 or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            r_tready    <= 1'b0;
            r_wr_ptr    <= '0;
            r_wr_commit <= '0;
            r_dropping  <= 1'b0;
        end else begin
            r_tready <= 1'b1;
            if (w_wr_beat) begin
                if (w_discard) begin
                    if (s_axis_tlast) begin
                        r_wr_ptr   <= r_wr_commit;
                        r_dropping <= 1'b0;
                    end else begin
                        r_dropping <= 1'b1;
                    end
                end else if (s_axis_tlast) begin
                    if (s_axis_tuser) begin
                        r_wr_ptr <= r_wr_commit;
                    end else begin
                        r_wr_ptr    <= w_wr_ptr_inc;
                        r_wr_commit <= w_wr_ptr_inc;
                    end
                end else begin
                    r_wr_ptr <= w_wr_ptr_inc;
                end
            end
        end
    end

    // Read side: IDLE/FETCH/STREAM sequencing, prefetch slot and output register
    always_ff @(posedge clk156 or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            r_rd_ptr   <= '0;
            r_pf_valid <= 1'b0;
            r_rd_state <= c_RD_IDLE;
            r_m_valid  <= 1'b0;
            r_m_last   <= 1'b0;
            r_m_data   <= '0;
            r_m_keep   <= '0;
        end else begin
            if (w_rd_en) begin
                r_rd_ptr   <= r_rd_ptr + c_PTR_ONE;
                r_pf_valid <= 1'b1;
            end else if (w_out_load) begin
                r_pf_valid <= 1'b0;
            end

            if (w_out_load) begin
                r_m_valid <= 1'b1;
                {r_m_last, r_m_keep, r_m_data} <= w_ram_rd_data;
            end else if (m_axis_tready) begin
                r_m_valid <= 1'b0;
            end

            if (w_out_load || (r_m_valid && !m_axis_tready)) begin
                r_rd_state <= c_RD_STREAM;
            end else if (w_rd_en || r_pf_valid) begin
                r_rd_state <= c_RD_FETCH;
            end else begin
                r_rd_state <= c_RD_IDLE;
            end
        end
    end

    assign s_axis_tready = r_tready;
    assign m_axis_tvalid = r_m_valid;
    assign m_axis_tlast  = r_m_last;
    assign m_axis_tdata  = r_m_data;
    assign m_axis_tkeep  = r_m_keep;
    assign m_axis_tuser  = 1'b0;
    assign debug         = {w_full, w_empty, r_dropping, r_rd_state, 3'b000};

`ifdef PKTBUF_STATS_EN
    logic        w_tx_evt;
    logic        w_drop_evt;
    logic [31:0] r_stat_tx;
    logic [31:0] r_stat_drop;

    assign w_tx_evt   = r_m_valid && m_axis_tready && r_m_last;
    assign w_drop_evt = w_wr_beat && s_axis_tlast && (w_discard || s_axis_tuser);

    // Wrapping frame counters
    always_ff @(posedge clk156 or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            r_stat_tx   <= '0;
            r_stat_drop <= '0;
        end else begin
            if (w_tx_evt) begin
                r_stat_tx <= r_stat_tx + 32'd1;
            end
            if (w_drop_evt) begin
                r_stat_drop <= r_stat_drop + 32'd1;
            end
        end
    end

    assign stat_tx_frames   = r_stat_tx;
    assign stat_drop_frames = r_stat_drop;
`else
    assign stat_tx_frames   = '0;
    assign stat_drop_frames = '0;
`endif

endmodule
`default_nettype wire
